// File: rtl/hsiao_scrub_pkg.sv
// Shared types and widths for the Hsiao (13,8) SECDED memory scrubber.
package hsiao_scrub_pkg;

  localparam int unsigned CODE_W = 13;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRead,
    StResp,
    StCheck,
    StWrite,
    StNext
  } scrub_state_e;

endpackage

// File: rtl/hsiao_scrub_timer.sv
// Inter-scrub countdown: load to INTERVAL-1, count down while enabled, expire at zero.
module hsiao_scrub_timer #(
  parameter int unsigned INTERVAL = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(INTERVAL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hsiao_scrub_controller.sv
// Background SECDED scrubber: periodically reads each word, counts errors, rewrites corrected
// words. Define HSIAO_SCRUB_WRITEBACK_EN to enable corrected-word writeback.
module hsiao_scrub_controller
  import hsiao_scrub_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned INTERVAL = 1024,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scrub_en,
  input  logic              host_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CODE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [CODE_W-1:0] mem_rdata,
  output logic [CODE_W-1:0] ecc_code,
  input  logic [DATA_W-1:0] ecc_data,
  input  logic              ecc_sec,
  input  logic              ecc_ded,
  output logic [DATA_W-1:0] enc_data,
  input  logic [CODE_W-1:0] enc_code,
  input  logic              err_clear,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              ded_flag,
  output logic [ADDR_W-1:0] ded_addr,
  output logic              pass_done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CODE_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  sec_count_q, sec_count_d;
  logic [CNT_W-1:0]  ded_count_q, ded_count_d;
  logic              ded_flag_q, ded_flag_d;
  logic [ADDR_W-1:0] ded_addr_q, ded_addr_d;
  logic              tmr_load, tmr_en, tmr_expire;
  logic              sec_event, ded_event;

  hsiao_scrub_timer #(
    .INTERVAL (INTERVAL)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    data_d    = data_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    enc_data  = data_q;
    pass_done = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    sec_event = 1'b0;
    ded_event = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (scrub_en) begin
          state_d  = StWait;
          tmr_load = 1'b1;
        end
      end
      // Disabling while waiting abandons the countdown; no word is in flight yet.
      StWait: begin
        if (!scrub_en) begin
          state_d = StIdle;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expire) state_d = StRead;
        end
      end
      StRead: begin
        if (!host_busy) begin
          mem_req = 1'b1;
          if (mem_ack) state_d = StResp;
        end
      end
      StResp: begin
        if (mem_rvalid) begin
          word_d  = mem_rdata;
          state_d = StCheck;
        end
      end
      // A word flagged both ways is treated as uncorrectable and never rewritten.
      StCheck: begin
        data_d  = ecc_data;
        state_d = StNext;
        if (ecc_ded) begin
          ded_event = 1'b1;
        end else if (ecc_sec) begin
          sec_event = 1'b1;
`ifdef HSIAO_SCRUB_WRITEBACK_EN
          state_d = StWrite;
`endif
        end
      end
      StWrite: begin
        if (!host_busy) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = enc_code;
          if (mem_ack) state_d = StNext;
        end
      end
      StNext: begin
        if (addr_q == LastAddr) begin
          addr_d    = '0;
          pass_done = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
        if (scrub_en) begin
          state_d  = StWait;
          tmr_load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A clear coinciding with an event restarts the record from that event.
  always_comb begin
    sec_count_d = sec_count_q;
    ded_count_d = ded_count_q;
    ded_flag_d  = ded_flag_q;
    ded_addr_d  = ded_addr_q;
    if (err_clear) begin
      sec_count_d = sec_event ? CNT_W'(1) : '0;
      ded_count_d = ded_event ? CNT_W'(1) : '0;
      ded_flag_d  = ded_event;
      ded_addr_d  = ded_event ? addr_q : '0;
    end else begin
      if (sec_event && (sec_count_q != '1)) sec_count_d = sec_count_q + 1'b1;
      if (ded_event && (ded_count_q != '1)) ded_count_d = ded_count_q + 1'b1;
      if (ded_event) begin
        ded_flag_d = 1'b1;
        if (!ded_flag_q) ded_addr_d = addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      word_q      <= '0;
      data_q      <= '0;
      sec_count_q <= '0;
      ded_count_q <= '0;
      ded_flag_q  <= 1'b0;
      ded_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      data_q      <= data_d;
      sec_count_q <= sec_count_d;
      ded_count_q <= ded_count_d;
      ded_flag_q  <= ded_flag_d;
      ded_addr_q  <= ded_addr_d;
    end
  end

  assign mem_addr  = addr_q;
  assign ecc_code  = word_q;
  assign sec_count = sec_count_q;
  assign ded_count = ded_count_q;
  assign ded_flag  = ded_flag_q;
  assign ded_addr  = ded_addr_q;

endmodule
